// File: rtl/code_converter_4b.sv
// Registered 4-bit code converter: bin<->Gray and BCD<->Excess-3, selected by mode.
// Output and err update one cycle after a nibble is sampled. err flags codes that are illegal for the selected mode.
module code_converter_4b #(
  parameter logic [1:0] DEFAULT_MODE = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       q,
  output logic       w,
  output logic       e,
  output logic       r,
  output logic       err
);

  localparam logic [1:0] MODE_BIN2GRAY = 2'b00;
  localparam logic [1:0] MODE_GRAY2BIN = 2'b01;
  localparam logic [1:0] MODE_BCD2XS3  = 2'b10;
  localparam logic [1:0] MODE_XS32BCD  = 2'b11;

  logic [3:0] x;
  logic [3:0] y_next;
  logic       err_next;
  logic [3:0] y_q;
  logic       err_q;
  logic [1:0] mode_q;

  assign x = {a, b, c, d};

  // Conversion uses the live mode input, so a mode change applies on the same edge that samples it.
  always_comb begin
    y_next   = 4'b0000;
    err_next = 1'b0;
    case (mode)
      MODE_BIN2GRAY: y_next = x ^ (x >> 1);
      MODE_GRAY2BIN: begin
        y_next[3] = x[3];
        y_next[2] = y_next[3] ^ x[2];
        y_next[1] = y_next[2] ^ x[1];
        y_next[0] = y_next[1] ^ x[0];
      end
      MODE_BCD2XS3: begin
        if (x <= 4'd9) y_next = x + 4'd3;
        else           err_next = 1'b1;
      end
      MODE_XS32BCD: begin
        if ((x >= 4'd3) && (x <= 4'd12)) y_next = x - 4'd3;
        else                             err_next = 1'b1;
      end
      default: begin
        y_next   = 4'b0000;
        err_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= 4'b0000;
      err_q  <= 1'b0;
      mode_q <= DEFAULT_MODE;
    end else begin
      y_q    <= y_next;
      err_q  <= err_next;
      mode_q <= mode;
    end
  end

  // mode_q records the mode behind the current outputs; it has no fanout of its own.
  logic unused_mode_q;
  assign unused_mode_q = ^mode_q;

  assign {q, w, e, r} = y_q;
  assign err          = err_q;

endmodule

// File: tb/tb_code_converter_4b.sv
// Directed bench for code_converter_4b: table sweeps, boundary codes, mode switching and async reset.
// Observed value is {q,w,e,r,err}; expectations are hand-computed constants.
module tb_code_converter_4b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       q, w, e, r, err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  logic [3:0] bin_tab [16]  = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                                4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

  code_converter_4b #(.DEFAULT_MODE(2'b10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .q    (q),
    .w    (w),
    .e    (e),
    .r    (r),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", tag, got, exp);
  endtask

  // Drive on the falling edge, then step just past the capturing rising edge.
  task automatic drive(input logic [1:0] m, input logic [3:0] x);
    @(negedge clk);
    mode = m;
    {a, b, c, d} = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("reset_t1", {q, w, e, r, err}, 5'b00000);
    mode = 2'b10;
    {a, b, c, d} = 4'b0111;
    @(posedge clk);
    #1;
    check("reset_held_over_edge", {q, w, e, r, err}, 5'b00000);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 4'(i));
      check($sformatf("b2g_%0d", i), {q, w, e, r, err}, {gray_tab[i], 1'b0});
    end
    drive(2'b00, 4'b0101); check("b2g_0101", {q, w, e, r, err}, 5'b01110);
    drive(2'b00, 4'b1111); check("b2g_1111", {q, w, e, r, err}, 5'b10000);

    drive(2'b01, 4'b0111); check("g2b_0111", {q, w, e, r, err}, 5'b01010);
    drive(2'b01, 4'b1000); check("g2b_1000", {q, w, e, r, err}, 5'b11110);
    for (int i = 0; i < 16; i++) begin
      drive(2'b01, 4'(i));
      check($sformatf("g2b_%0d", i), {q, w, e, r, err}, {bin_tab[i], 1'b0});
    end

    drive(2'b10, 4'b0000); check("bcd_0000", {q, w, e, r, err}, 5'b00110);
    drive(2'b10, 4'b0111); check("bcd_0111", {q, w, e, r, err}, 5'b10100);
    drive(2'b10, 4'b1001); check("bcd_1001", {q, w, e, r, err}, 5'b11000);
    for (int i = 10; i < 16; i++) begin
      drive(2'b10, 4'(i));
      check($sformatf("bcd_bad_%0d", i), {q, w, e, r, err}, 5'b00001);
    end

    drive(2'b11, 4'b0011); check("xs3_0011", {q, w, e, r, err}, 5'b00000);
    drive(2'b11, 4'b1010); check("xs3_1010", {q, w, e, r, err}, 5'b01110);
    drive(2'b11, 4'b1100); check("xs3_1100", {q, w, e, r, err}, 5'b10010);
    drive(2'b11, 4'b0000); check("xs3_bad_0000", {q, w, e, r, err}, 5'b00001);
    drive(2'b11, 4'b0010); check("xs3_bad_0010", {q, w, e, r, err}, 5'b00001);
    drive(2'b11, 4'b1101); check("xs3_bad_1101", {q, w, e, r, err}, 5'b00001);
    drive(2'b11, 4'b1111); check("xs3_bad_1111", {q, w, e, r, err}, 5'b00001);

    drive(2'b00, 4'b0101); check("msw_00", {q, w, e, r, err}, 5'b01110);
    drive(2'b01, 4'b0101); check("msw_01", {q, w, e, r, err}, 5'b01100);
    drive(2'b10, 4'b0101); check("msw_10", {q, w, e, r, err}, 5'b10000);
    drive(2'b11, 4'b0101); check("msw_11", {q, w, e, r, err}, 5'b00100);

    drive(2'b10, 4'b0111); check("pre_reset", {q, w, e, r, err}, 5'b10100);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {q, w, e, r, err}, 5'b00000);
    #1 rst_n = 1'b1;
    #1 check("after_release", {q, w, e, r, err}, 5'b00000);
    @(posedge clk);
    #1 check("restore", {q, w, e, r, err}, 5'b10100);

    drive(2'b10, 4'b1100); check("pre_reset_err", {q, w, e, r, err}, 5'b00001);
    #2 rst_n = 1'b0;
    #1 check("async_reset_err", {q, w, e, r, err}, 5'b00000);
    #1 rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
